// File: rtl/load_unit.sv
// Load unit: takes one load from execute, reads the aligned word from data memory,
// and returns the extended byte/halfword/word to writeback. Rejects bad loads and aborts on a memory timeout.
module load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  input  logic        wb_ready,
  output logic        misaligned,
  output logic        timeout
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    type_q, type_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic        legal, reject;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;

  always_comb begin
    legal = (req_type == 3'b000) || (req_type == 3'b001) || (req_type == 3'b010) ||
            (req_type == 3'b100) || (req_type == 3'b101);
    reject = !legal ||
             ((req_type[1:0] == 2'b01) && req_addr[0]) ||
             ((req_type == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  // Extraction uses the captured type/offset so the request bus may change while waiting.
  always_comb begin
    sel_b = mem_rdata[{off_q, 3'b000} +: 8];
    sel_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (type_q[1:0])
      2'b00:   ext = {{24{sel_b[7] & ~type_q[2]}}, sel_b};
      2'b01:   ext = {{16{sel_h[15] & ~type_q[2]}}, sel_h};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    off_d   = off_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        type_d  = req_type;
        off_d   = req_addr[1:0];
        rd_d    = req_rd;
        addr_d  = {req_addr[31:2], 2'b00};
        cnt_d   = '0;
        state_d = reject ? S_ERR : S_REQ;
      end
      S_ERR: state_d = S_IDLE;
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q == TMAX) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          data_d  = ext;
        end else if (cnt_q == TMAX) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_RESP: if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = addr_q;
  assign wb_valid   = (state_q == S_RESP);
  assign wb_data    = data_q;
  assign wb_rd      = rd_q;
  assign misaligned = (state_q == S_ERR);
  assign timeout    = to_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: extraction, handshake stalls, rejects, timeout and async reset.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misaligned, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  load_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_ready(wb_ready),
    .misaligned(misaligned), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full legal load: gd cycles before grant, rd cycles of WAIT before rvalid, wd cycles of wb stall.
  task automatic run_load(input string tag, input logic [2:0] ty, input logic [31:0] a,
                          input logic [4:0] rdi, input int gd, input int rdly, input int wd,
                          input logic [31:0] rdata, input logic [31:0] exp);
    logic [31:0] waddr;
    waddr = {a[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1'b1; req_type = ty; req_addr = a; req_rd = rdi;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_type = 3'b111;
    chk({tag, " req_ready low"}, 32'(req_ready), 32'd0);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, " mem_addr"}, mem_addr, waddr);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk({tag, " mem_req held"}, 32'(mem_req), 32'd1);
      chk({tag, " mem_addr held"}, mem_addr, waddr);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk({tag, " mem_req drop"}, 32'(mem_req), 32'd0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk({tag, " wb_valid early"}, 32'(wb_valid), 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_A5A5;
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, " wb_data"}, wb_data, exp);
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'(rdi));
    for (int i = 0; i < wd; i++) begin
      @(negedge clk);
      chk({tag, " wb_valid stall"}, 32'(wb_valid), 32'd1);
      chk({tag, " wb_data stall"}, wb_data, exp);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk({tag, " wb_valid done"}, 32'(wb_valid), 32'd0);
    chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_bad(input string tag, input logic [2:0] ty, input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1; req_type = ty; req_addr = a; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " misaligned"}, 32'(misaligned), 32'd1);
    chk({tag, " req_ready low"}, 32'(req_ready), 32'd0);
    chk({tag, " no mem_req"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    chk({tag, " misaligned clr"}, 32'(misaligned), 32'd0);
    chk({tag, " no mem_req 2"}, 32'(mem_req), 32'd0);
    chk({tag, " no wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, " idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_addr = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    #12;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst misaligned", 32'(misaligned), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_load("LW",  3'b010, 32'h0000_0100, 5'd3,  0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("LB",  3'b000, 32'h0000_0103, 5'd4,  0, 0, 0, 32'h8011_2233, 32'hFFFF_FF80);
    run_load("LBU", 3'b100, 32'h0000_0103, 5'd5,  0, 0, 0, 32'h8011_2233, 32'h0000_0080);
    run_load("LB1", 3'b000, 32'h0000_0101, 5'd6,  0, 0, 0, 32'h8011_2233, 32'h0000_0022);
    run_load("LH",  3'b001, 32'h0000_0102, 5'd7,  0, 0, 0, 32'h8001_ABCD, 32'hFFFF_8001);
    run_load("LHU", 3'b101, 32'h0000_0102, 5'd8,  0, 0, 0, 32'h8001_ABCD, 32'h0000_8001);
    run_load("LH0", 3'b001, 32'h0000_0200, 5'd10, 0, 0, 0, 32'h8001_ABCD, 32'hFFFF_ABCD);
    run_load("LWs", 3'b010, 32'h1234_5678, 5'd31, 3, 2, 4, 32'hCAFE_F00D, 32'hCAFE_F00D);

    run_bad("LHmis", 3'b001, 32'h0000_0101);
    run_bad("LWmis", 3'b010, 32'h0000_0102);
    run_bad("ILL",   3'b011, 32'h0000_0100);

    // Timeout: grant on first REQ cycle, then rvalid never comes.
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'b010; req_addr = 32'h0000_0400; req_rd = 5'd12;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("TO still busy", 32'(req_ready), 32'd0);
      chk("TO no pulse yet", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("TO pulse", 32'(timeout), 32'd1);
    chk("TO req_ready", 32'(req_ready), 32'd1);
    chk("TO no wb", 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("TO pulse clr", 32'(timeout), 32'd0);
    chk("TO late rvalid", 32'(wb_valid), 32'd0);
    chk("TO idle", 32'(req_ready), 32'd1);

    // Async reset while in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'b010; req_addr = 32'h0000_0800; req_rd = 5'd13;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("RST pre wait", 32'(mem_req), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("RST req_ready", 32'(req_ready), 32'd1);
    chk("RST mem_addr", mem_addr, 32'd0);
    chk("RST wb_data", wb_data, 32'd0);
    chk("RST wb_rd", 32'(wb_rd), 32'd0);
    chk("RST wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("RST late rvalid", 32'(wb_valid), 32'd0);
    chk("RST late data", wb_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_unit.md
# load_unit

Sequential load-side memory unit, the read counterpart of the store path. It accepts a load request (type, byte address, destination register) from the execute stage and issues a word-aligned read to data memory with a request/grant handshake. It waits for the read data, then extracts and sign- or zero-extends the addressed byte, halfword or word and presents it to writeback on a valid/ready handshake. It flags misaligned or illegal loads without touching memory, and it aborts with a pulse if memory does not respond within a bounded time.

## Interface
- TIMEOUT, 16, max cycles spent in REQ+WAIT before abort; must be >= 2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_type  in  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are illegal
- req_addr  in  32  byte address (ALU result)
- req_rd  in  5  destination register index
- mem_req  out  1  memory read request
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  writeback data valid
- wb_data  out  32  extended load result
- wb_rd  out  5  destination register
- wb_ready  in  1  writeback accepts the result
- misaligned  out  1  one-cycle pulse: misaligned or illegal load rejected
- timeout  out  1  one-cycle pulse: memory did not respond

## Operation
- States: IDLE, ERR, REQ, WAIT, RESP. Reset enters IDLE.
- `req_ready` = (state==IDLE). A request is accepted on a clock edge where `req_valid & req_ready` is true. On acceptance the unit captures `req_type`, `req_addr[1:0]` and `req_rd`, drives `mem_addr`, and clears the timeout counter.
- Reject condition: `req_type` is illegal, or LH/LHU with addr[0]=1, or LW with addr[1:0]!=00. A rejected request goes IDLE->ERR. ERR lasts one cycle with `misaligned`=1 and then returns to IDLE. There is no memory access and no writeback.
- Legal request: IDLE->REQ. In REQ, `mem_req`=1 and `mem_addr` is held stable. `mem_gnt` high at an edge moves REQ->WAIT and `mem_req` drops.
- WAIT: `mem_rvalid` high at an edge captures the extracted result into `wb_data` and moves WAIT->RESP. `mem_rvalid` is ignored in every state except WAIT.
- Extraction, with off = addr[1:0]:
  - LB/LBU select mem_rdata[8*off+7 : 8*off].
  - LH/LHU select mem_rdata[31:16] if addr[1]=1, else mem_rdata[15:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - LW passes the word through.
- RESP: `wb_valid`=1. `wb_data` and `wb_rd` are held stable until `wb_ready`=1 at an edge, then the state goes to IDLE.
- Timeout: a counter of width clog2(TIMEOUT) runs in REQ and WAIT.
  - If the cycle's progress event (gnt in REQ, rvalid in WAIT) is absent and cnt==TIMEOUT-1, the state goes to IDLE and `timeout` pulses for one cycle (registered). No writeback occurs.
  - Otherwise cnt increments.
  - A progress event on the final cycle takes priority over timeout.

## Timing
- Reset values: state IDLE, `req_ready`=1, `mem_req`=0, `mem_addr`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `misaligned`=0, `timeout`=0, counter 0.
- Reset asserted mid-operation: outputs return to these values immediately and asynchronously. A late `mem_rvalid` after reset is ignored.
- Best-case latency, with gnt on the first REQ cycle and rvalid on the first WAIT cycle:
  - accept at edge T;
  - REQ during T+1;
  - WAIT during T+2;
  - `wb_valid` from T+3.
- Back-to-back requests: the next request can be accepted on the edge one cycle after the `wb_valid & wb_ready` edge, when `req_ready` is high again. There is no overlap.
- `misaligned` is high in the cycle after the accepting edge. `req_ready` is low during that cycle.
- `timeout` is high in the first IDLE cycle after abort. `req_ready` is also high in that cycle.
- Total REQ+WAIT residency before timeout is exactly TIMEOUT cycles.

## Test plan
- LW at 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> `mem_addr`=0x100, `wb_valid` 3 cycles after accept, `wb_data`=0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, rdata 0x80112233 -> `wb_data`=0xFFFFFF80 for LB and 0x00000080 for LBU; `mem_addr`=0x100 in both cases.
- LH at 0x102 and LHU at 0x102, rdata 0x8001ABCD -> `wb_data`=0xFFFF8001 and 0x00008001 respectively.
- LH at 0x101, LW at 0x102, and req_type 011 -> each gives a one-cycle `misaligned` pulse, no `mem_req`, and no `wb_valid`.
- LW with gnt delayed 3 cycles, rvalid delayed 2 more, and `wb_ready` held low 4 cycles -> `mem_addr`/`mem_req` stable until grant, and `wb_data` stable until the handshake.
- TIMEOUT=16, grant given but rvalid never sent -> `timeout` pulses after 16 REQ+WAIT cycles, then a late rvalid is ignored. A second test asserts rst while in WAIT -> all outputs reach reset values immediately.
